// File: rtl/load_store_controller_pkg.sv
// Shared constants and state encoding for the load/store sequencing stage.
package load_store_controller_pkg;

    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic legal;
        legal = 1'b0;
        if (op == OpcLoad) begin
            legal = (f3 == F3Lb) || (f3 == F3Lh) || (f3 == F3Lw) ||
                    (f3 == F3Lbu) || (f3 == F3Lhu);
        end else if (op == OpcStore) begin
            legal = (f3 == F3Sb) || (f3 == F3Sh) || (f3 == F3Sw);
        end
        return legal;
    endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Moves the addressed byte/halfword of a read word down to bit 0 and extends it.
module load_data_aligner
    import load_store_controller_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = mem_rdata >> {addr_lo, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3Lb:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3Lh:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3Lbu:   data = {24'h0, shifted[7:0]};
            F3Lhu:   data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_controller.sv
// Sequences one load/store to the data-memory port: checks it, drives the port,
// stalls execute until completion or timeout, and returns extended load data.
module load_store_controller
    import load_store_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall,
    output logic        done,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_error
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [1:0] addr_lo_q;
    logic [2:0] funct3_q;
    logic mem_enable_q, mem_write_q;
    logic [3:0] mem_mask_q;
    logic [31:0] mem_address_q, mem_wdata_q, load_data_q;
    logic misaligned_q, illegal_q, bus_error_q;

    logic req_legal, req_aligned, accept, cnt_expired;
    logic [3:0] req_mask;
    logic [31:0] req_wdata, aligned_data;

    // Request decode: funct3[1:0] gives the access size for both loads and stores.
    always_comb begin
        req_legal = is_legal(opcode, funct3);
        case (funct3[1:0])
            2'b00: begin
                req_aligned = 1'b1;
                req_mask    = 4'b0001 << address[1:0];
                req_wdata   = {4{store_data[7:0]}};
            end
            2'b01: begin
                req_aligned = ~address[0];
                req_mask    = address[1] ? 4'b1100 : 4'b0011;
                req_wdata   = {2{store_data[15:0]}};
            end
            default: begin
                req_aligned = (address[1:0] == 2'b00);
                req_mask    = 4'b1111;
                req_wdata   = store_data;
            end
        endcase
        accept      = (state_q == StIdle) && req_valid && req_legal && req_aligned;
        cnt_expired = (cnt_q == CntLast);
    end

    load_data_aligner u_aligner (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_lo_q),
        .funct3    (funct3_q),
        .data      (aligned_data)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StAccess;
            end
            StAccess: begin
                if (mem_done) begin
                    state_d = StDone;
                end else if (cnt_expired) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall      = accept || (state_q == StAccess);
        done       = (state_q == StDone);
        load_valid = (state_q == StDone) && !mem_write_q;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            addr_lo_q     <= '0;
            funct3_q      <= '0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_mask_q    <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            load_data_q   <= '0;
            misaligned_q  <= 1'b0;
            illegal_q     <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            illegal_q    <= (state_q == StIdle) && req_valid && !req_legal;
            misaligned_q <= (state_q == StIdle) && req_valid && req_legal && !req_aligned;
            bus_error_q  <= (state_q == StAccess) && !mem_done && cnt_expired;
            if (accept) begin
                cnt_q         <= '0;
                addr_lo_q     <= address[1:0];
                funct3_q      <= funct3;
                mem_enable_q  <= 1'b1;
                mem_write_q   <= (opcode == OpcStore);
                mem_mask_q    <= req_mask;
                mem_address_q <= {address[31:2], 2'b00};
                mem_wdata_q   <= req_wdata;
            end else if (state_q == StAccess) begin
                if (mem_done) begin
                    mem_enable_q <= 1'b0;
                    if (!mem_write_q) load_data_q <= aligned_data;
                end else if (cnt_expired) begin
                    mem_enable_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

    assign mem_enable  = mem_enable_q;
    assign mem_write   = mem_write_q;
    assign mem_mask    = mem_mask_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign load_data   = load_data_q;
    assign misaligned  = misaligned_q;
    assign illegal     = illegal_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_load_store_controller.sv
// Directed and randomized checks of load_store_controller against an arithmetic reference model.
module tb_load_store_controller;

    localparam int T = 4;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] address, store_data, mem_rdata;
    logic        mem_done;
    logic        mem_enable, mem_write, stall, done, load_valid, misaligned, illegal, bus_error;
    logic [3:0]  mem_mask;
    logic [31:0] mem_address, mem_wdata, load_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_load = 32'h0;

    load_store_controller #(.TIMEOUT_CYCLES(T)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .opcode      (opcode),
        .funct3      (funct3),
        .address     (address),
        .store_data  (store_data),
        .mem_enable  (mem_enable),
        .mem_write   (mem_write),
        .mem_mask    (mem_mask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .stall       (stall),
        .done        (done),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .illegal     (illegal),
        .bus_error   (bus_error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
    // lat = ACCESS cycle index at which mem_done rises; lat >= T means never.
    task automatic run_req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int lat, input logic [31:0] rd);
        logic is_load, legal, aligned, tmo;
        int sz, ncyc;
        logic [3:0] emask;
        logic [31:0] ewdata, eload;
        is_load = (op == LOAD);
        legal = (is_load && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                (op == STORE && (f3 inside {3'd0, 3'd1, 3'd2}));
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        aligned = (a % sz) == 0;
        emask = (sz == 4) ? 4'hF : 4'((sz == 1 ? 1 : 3) << a[1:0]);
        ewdata = (sz == 1) ? sd[7:0] * 32'h01010101 :
                 (sz == 2) ? sd[15:0] * 32'h00010001 : sd;
        eload = rd >> (8 * a[1:0]);
        if (sz == 1) begin
            eload = eload & 32'hFF;
            if (!f3[2] && eload[7]) eload = eload - 32'd256;
        end else if (sz == 2) begin
            eload = eload & 32'hFFFF;
            if (!f3[2] && eload[15]) eload = eload - 32'd65536;
        end
        tmo = (lat >= T);
        ncyc = tmo ? T : lat + 1;

        req_valid = 1'b1; opcode = op; funct3 = f3; address = a; store_data = sd;
        @(negedge CLK);
        check("accept_stall", stall, legal && aligned);
        @(posedge CLK); #1 req_valid = 1'b0;
        if (!legal || !aligned) begin
            @(negedge CLK);
            check("illegal_pulse", illegal, !legal);
            check("misaligned_pulse", misaligned, legal && !aligned);
            check("reject_no_enable", mem_enable, 1'b0);
            check("reject_stall", stall, 1'b0);
            @(posedge CLK); #1;
            @(negedge CLK);
            check("illegal_end", illegal, 1'b0);
            check("misaligned_end", misaligned, 1'b0);
            check("reject_no_enable2", mem_enable, 1'b0);
            @(posedge CLK); #1;
            return;
        end
        for (int k = 0; k < ncyc; k++) begin
            mem_done = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            @(negedge CLK);
            check("access_enable", mem_enable, 1'b1);
            check("access_stall", stall, 1'b1);
            if (k == 0) begin
                check("mem_write", mem_write, !is_load);
                check("mem_mask", mem_mask, emask);
                check("mem_address", mem_address, a & 32'hFFFF_FFFC);
                if (!is_load) check("mem_wdata", mem_wdata, ewdata);
            end
            @(posedge CLK); #1 mem_done = 1'b0;
        end
        @(negedge CLK);
        check("end_enable", mem_enable, 1'b0);
        check("end_stall", stall, 1'b0);
        if (tmo) begin
            check("bus_error_pulse", bus_error, 1'b1);
            check("timeout_no_done", done, 1'b0);
            check("timeout_load_data", load_data, last_load);
        end else begin
            if (is_load) last_load = eload;
            check("done_pulse", done, 1'b1);
            check("load_valid", load_valid, is_load);
            check("no_bus_error", bus_error, 1'b0);
            check("load_data", load_data, last_load);
            mem_done = 1'($urandom);
        end
        @(posedge CLK); #1 mem_done = 1'b0;
        @(negedge CLK);
        check("pulse_end_done", done, 1'b0);
        check("pulse_end_lv", load_valid, 1'b0);
        check("pulse_end_berr", bus_error, 1'b0);
        check("idle_enable", mem_enable, 1'b0);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [6:0] op;
        logic [31:0] a1, a2;
        logic exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic exp_done [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0; req_valid = 1'b0; opcode = '0; funct3 = '0; address = '0;
        store_data = '0; mem_rdata = '0; mem_done = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_enable", mem_enable, 1'b0);
        check("rst_mask", mem_mask, 4'h0);
        check("rst_address", mem_address, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_pulses", {done, load_valid, misaligned, illegal, bus_error, stall}, 6'h0);
        @(posedge CLK); #1 reset_n = 1'b1;

        // Directed plan items
        run_req(LOAD, 3'b000, 32'h1003, 32'h0, 1, 32'h80FF1234);
        run_req(LOAD, 3'b100, 32'h1003, 32'h0, 1, 32'h80FF1234);
        run_req(STORE, 3'b001, 32'h2002, 32'h1234BEEF, 0, 32'h0);
        run_req(LOAD, 3'b010, 32'h1002, 32'h0, 0, 32'h0);
        run_req(LOAD, 3'b011, 32'h1000, 32'h0, 0, 32'h0);
        run_req(LOAD, 3'b010, 32'h0, 32'h0, 99, 32'h0);
        run_req(LOAD, 3'b010, 32'h8, 32'h0, 3, 32'hCAFEF00D);
        run_req(LOAD, 3'b001, 32'h2, 32'h0, 0, 32'h9ABC0000);

        // Asynchronous reset in the middle of an access
        req_valid = 1'b1; opcode = LOAD; funct3 = 3'b010; address = 32'h40;
        @(posedge CLK); #1 req_valid = 1'b0;
        @(negedge CLK);
        check("pre_rst_enable", mem_enable, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_enable", mem_enable, 1'b0);
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_mask", mem_mask, 4'h0);
        last_load = 32'h0;
        mem_done = 1'b1; mem_rdata = 32'h12345678;
        repeat (2) @(posedge CLK);
        #2 reset_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("late_done", done, 1'b0);
            check("late_lv", load_valid, 1'b0);
            check("late_enable", mem_enable, 1'b0);
            check("late_load_data", load_data, 32'h0);
        end
        mem_done = 1'b0;
        @(posedge CLK); #1;

        // Two stores with req_valid held
        a1 = 32'h3000; a2 = 32'h3004;
        req_valid = 1'b1; opcode = STORE; funct3 = 3'b010;
        for (int c = 0; c < 6; c++) begin
            address = (c < 2) ? a1 : a2;
            store_data = (c < 2) ? 32'h11111111 : 32'h22222222;
            mem_done = (c == 1 || c == 4);
            if (c == 5) req_valid = 1'b0;
            @(negedge CLK);
            check("b2b_stall", stall, exp_stall[c]);
            check("b2b_done", done, exp_done[c]);
            if (c == 1) check("b2b_addr1", mem_address, a1);
            if (c == 4) begin
                check("b2b_addr2", mem_address, a2);
                check("b2b_wdata2", mem_wdata, 32'h22222222);
            end
            @(posedge CLK); #1;
        end
        mem_done = 1'b0;

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            op = (r < 5) ? LOAD : (r < 9) ? STORE : 7'($urandom);
            run_req(op, 3'($urandom), $urandom, $urandom, $urandom_range(0, 5), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
- Sequencing stage directly upstream of the data-memory load/store port.
- Accepts one load/store request from execute and checks alignment.
- Drives the memory port with an aligned lane mask and replicated store data, then holds `stall` until the access completes.
- Returns sign/zero-extended load data to writeback, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without mem_done before the access is aborted; must be ≥ 1.

Ports:
- CLK  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute presents a request this cycle
- opcode  in  7  instruction opcode
- funct3  in  3  load/store width/sign code
- address  in  32  effective byte address
- store_data  in  32  rs2 value
- mem_enable  out  1  memory access active
- mem_write  out  1  1 = store, 0 = load
- mem_mask  out  4  byte-lane enables; bit i covers data bits [8i+7:8i]
- mem_address  out  32  word-aligned address (address[1:0] forced to 0)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when mem_done=1
- mem_done  in  1  memory completion strobe
- stall  out  1  freeze upstream pipeline
- done  out  1  one-cycle pulse, access completed
- load_valid  out  1  one-cycle pulse, load_data valid
- load_data  out  32  extended load result
- misaligned  out  1  one-cycle pulse
- illegal  out  1  one-cycle pulse, unsupported opcode/funct3
- bus_error  out  1  one-cycle pulse, timeout

Behaviour:
- Reset: state=IDLE; all registered outputs 0, including mem_enable, mem_mask, mem_address, mem_wdata, load_data and the pulses; counter=0. Reset is asynchronous, so mem_enable falls immediately when reset_n falls, including mid-access.
- States: IDLE, ACCESS, DONE.
- IDLE, no req_valid: stay in IDLE.
- IDLE, req_valid, unsupported opcode/funct3: illegal pulses next cycle; stay in IDLE; no memory access.
  - Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Legal stores: SB 000, SH 001, SW 010.
- IDLE, req_valid, misaligned: misaligned pulses next cycle; stay in IDLE; no memory access.
  - Halfword is misaligned when address[0]=1.
  - Word is misaligned when address[1:0]≠0.
- IDLE, req_valid, legal and aligned: register the access and go to ACCESS.
  - Registered fields: address[1:0], funct3, mem_write, mem_mask, mem_address, mem_wdata. mem_enable=1 from the next cycle.
  - mem_mask: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - mem_wdata: SB = {4{store_data[7:0]}}; SH = {2{store_data[15:0]}}; SW = store_data.
- ACCESS, mem_done=1: drop mem_enable and go to DONE. On a load, also register the extended result into load_data.
  - Shift mem_rdata right by 8*addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word through.
- ACCESS, no mem_done, counter = TIMEOUT_CYCLES-1: drop mem_enable, pulse bus_error next cycle, return to IDLE; load_data is unchanged.
- ACCESS, otherwise: increment counter.
- DONE: done=1 for one cycle, plus load_valid=1 if the access was a load; go to IDLE. New requests are not accepted in DONE.
- Counter: width $clog2(TIMEOUT_CYCLES+1); cleared on entry to ACCESS.
- stall (combinational) = (state==IDLE && req_valid && legal && aligned) || state==ACCESS. It is low in DONE and for illegal or misaligned requests.
- mem_done outside ACCESS is ignored.
- Minimum latency: accept → ACCESS (1 cycle) → DONE (≥1 cycle).
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE.

Decomposition:
- Shared package:
  - opcode constants: LOAD 7'b0000011, STORE 7'b0100011
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW
  - state encoding: IDLE/ACCESS/DONE, 2 bits
- Sub-module load_data_aligner: combinational shift/extend taking mem_rdata, addr[1:0] and funct3, producing 32-bit data.

Test Plan:
- LB at 0x1003, mem_rdata=0x80FF1234, done after 2 cycles → mem_mask=1000, mem_address=0x1000; load_data=0xFFFFFF80, load_valid pulses. LBU, same stimulus → load_data=0x00000080.
- SH at 0x2002, store_data=0x1234BEEF → mem_write=1, mem_mask=1100, mem_wdata=0xBEEFBEEF; done pulses, load_valid stays 0.
- LW at 0x1002 → misaligned pulses once, mem_enable never rises, stall=0. funct3=011 with the LOAD opcode → illegal pulses.
- TIMEOUT_CYCLES=4, LW at 0x0, mem_done held 0 → mem_enable high exactly 4 cycles, bus_error pulses, FSM returns to IDLE, next request accepted.
- reset_n driven low during ACCESS → mem_enable and stall fall immediately; a late mem_done after reset produces no done pulse.
- Two SWs back-to-back with req_valid held → second accepted the cycle after the first's done; stall low only in the DONE cycle.
